// File: rtl/mp3_mon_pkg.sv
// Shared types for the retire-stage commit monitor.
// Halt causes, monitor FSM states and the x1 register index.
package mp3_mon_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        MAGIC   = 2'd1,
        LOOP    = 2'd2,
        TIMEOUT = 2'd3
    } halt_cause_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } mon_state_t;

    localparam logic [4:0] X1_IDX = 5'd1;

endpackage

// File: rtl/lane_prefix_count.sv
// Exclusive prefix popcount over a lane mask.
// prefix[i] counts set bits below lane i; total counts all of them.
module lane_prefix_count #(
    parameter int NUM_LANES = 1,
    parameter int CW        = $clog2(NUM_LANES + 1)
) (
    input  logic [NUM_LANES-1:0]    mask,
    output logic [NUM_LANES*CW-1:0] prefix,
    output logic [CW-1:0]           total
);

    always_comb begin
        prefix = '0;
        total  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            prefix[i*CW +: CW] = total;
            total              = total + CW'(mask[i]);
        end
    end

endmodule

// File: rtl/commit_monitor.sv
// Retire-stage monitor: numbers committed lanes in RVFI order
// and raises a sticky halt on magic x1 write, self-loop or idle timeout.
module commit_monitor
    import mp3_mon_pkg::*;
#(
    parameter int          NUM_LANES   = 1,
    parameter int          XLEN        = 32,
    parameter int          ORDER_W     = 64,
    parameter int          LOOP_THRESH = 2,
    parameter int          WDOG_CYCLES = 100000,
    parameter logic [31:0] HALT_MAGIC  = 32'h600D600D
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LANES-1:0]         lane_valid,
    input  logic [NUM_LANES*XLEN-1:0]    lane_pc,
    input  logic [NUM_LANES*XLEN-1:0]    lane_next_pc,
    input  logic [NUM_LANES-1:0]         lane_rd_we,
    input  logic [NUM_LANES*5-1:0]       lane_rd_addr,
    input  logic [NUM_LANES*XLEN-1:0]    lane_rd_wdata,
    output logic [NUM_LANES-1:0]         commit_mask,
    output logic                         commit,
    output logic [NUM_LANES*ORDER_W-1:0] lane_order,
    output logic [ORDER_W-1:0]           retired_total,
    output logic                         halt,
    output halt_cause_t                  halt_cause
);

    localparam int CW   = $clog2(NUM_LANES + 1);
    localparam int LC_W = $clog2(LOOP_THRESH + 1);
    localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    localparam logic [XLEN-1:0] MAGIC_V = XLEN'(HALT_MAGIC);
    localparam logic [LC_W-1:0] LC_MAX  = LC_W'(LOOP_THRESH);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    mon_state_t                   state_q, state_d;
    logic [ORDER_W-1:0]           order_q, order_d;
    logic [LC_W-1:0]              loop_q, loop_d;
    logic [WD_W-1:0]              wdog_q, wdog_d;
    logic [NUM_LANES-1:0]         mask_q;
    logic [NUM_LANES*ORDER_W-1:0] lane_order_q, lane_order_d;
    halt_cause_t                  cause_q, cause_d;

    logic [NUM_LANES-1:0]    acc;
    logic [NUM_LANES*CW-1:0] prefix;
    logic [CW-1:0]           total;
    logic                    hit;
    logic                    timeout;
    logic                    magic_c;
    halt_cause_t             hit_cause;

    // Walk lanes in order; the first magic/loop trigger closes the window.
    always_comb begin
        acc       = '0;
        hit       = 1'b0;
        hit_cause = NONE;
        magic_c   = 1'b0;
        loop_d    = loop_q;
        wdog_d    = wdog_q;
        timeout   = 1'b0;
        if (state_q == RUN) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_valid[i] && !hit) begin
                    acc[i]  = 1'b1;
                    magic_c = lane_rd_we[i]
                            && lane_rd_addr[i*5 +: 5] == X1_IDX
                            && lane_rd_wdata[i*XLEN +: XLEN] == MAGIC_V;
                    if (lane_next_pc[i*XLEN +: XLEN] == lane_pc[i*XLEN +: XLEN])
                        loop_d = loop_d + LC_W'(1);
                    else
                        loop_d = '0;
                    if (magic_c) begin
                        hit       = 1'b1;
                        hit_cause = MAGIC;
                    end else if (loop_d == LC_MAX) begin
                        hit       = 1'b1;
                        hit_cause = LOOP;
                    end
                end
            end
            if (lane_valid != '0) begin
                wdog_d = '0;
            end else if (WDOG_CYCLES != 0) begin
                if (wdog_q == WD_LAST)
                    timeout = 1'b1;
                else
                    wdog_d = wdog_q + WD_W'(1);
            end
        end
    end

    lane_prefix_count #(
        .NUM_LANES(NUM_LANES),
        .CW       (CW)
    ) u_prefix (
        .mask  (acc),
        .prefix(prefix),
        .total (total)
    );

    always_comb begin
        order_d      = order_q + ORDER_W'(total);
        lane_order_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (acc[i])
                lane_order_d[i*ORDER_W +: ORDER_W] =
                    order_q + ORDER_W'(prefix[i*CW +: CW]);
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            RUN: begin
                if (hit) begin
                    state_d = HALTED;
                    cause_d = hit_cause;
                end else if (timeout) begin
                    state_d = HALTED;
                    cause_d = TIMEOUT;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            order_q      <= '0;
            loop_q       <= '0;
            wdog_q       <= '0;
            mask_q       <= '0;
            lane_order_q <= '0;
            cause_q      <= NONE;
        end else begin
            state_q      <= state_d;
            order_q      <= order_d;
            loop_q       <= loop_d;
            wdog_q       <= wdog_d;
            mask_q       <= acc;
            lane_order_q <= lane_order_d;
            cause_q      <= cause_d;
        end
    end

    assign commit_mask   = mask_q;
    assign commit        = |mask_q;
    assign lane_order    = lane_order_q;
    assign retired_total = order_q;
    assign halt          = (state_q == HALTED);
    assign halt_cause    = cause_q;

endmodule
